// File: rtl/step_dir_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module   : step_dir_decoder_if
//  Purpose  : Signal bundle between a STEP/DIR source/consumer and the
//             step_dir_decoder receive block.
//  Revision : 1.0  initial release
// ============================================================================
interface step_dir_decoder_if #(
  parameter int POS_W    = 17,
  parameter int PERIOD_W = 20
);
  logic                step_in;
  logic                dir_in;
  logic                enable_in;
  logic                clear;
  logic [POS_W-1:0]    position;
  logic                step_valid;
  logic                step_dir;
  logic [PERIOD_W-1:0] period;
  logic                period_valid;
  logic                moving;
  logic                dir_err;

  // Side that drives the STEP/DIR lines and control, and observes results
  modport master (
    output step_in, dir_in, enable_in, clear,
    input  position, step_valid, step_dir, period, period_valid, moving, dir_err
  );

  // Decoder side
  modport slave (
    input  step_in, dir_in, enable_in, clear,
    output position, step_valid, step_dir, period, period_valid, moving, dir_err
  );
endinterface
`default_nettype wire

// File: rtl/step_dir_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : step_dir_decoder
//  Purpose  : Receive side of a STEP/DIR motor interface. Synchronises and
//             glitch-filters STEP and DIR, accumulates a signed position,
//             measures the interval between steps and reports moving/idle.
//  Options  : define STEP_DECODER_DIR_CHECK_EN to enable the DIR-to-STEP
//             setup check that drives dir_err (otherwise dir_err is 0).
//  Revision : 1.0  initial release
// ============================================================================
module step_dir_decoder #(
  parameter int POS_W     = 17,
  parameter int PERIOD_W  = 20,
  parameter int FILT_LEN  = 3,
  parameter int DIR_SETUP = 27,
  parameter int TIMEOUT   = 27000000
) (
  input  logic                clk,
  input  logic                rst_n,
  step_dir_decoder_if.slave   bus
);

  // The interval counter also has to reach TIMEOUT-1, which may exceed the
  // period range, so it is widened; the reported period is still saturated
  // to PERIOD_W bits, which is all that is visible outside.
  localparam int CNT_W_TO = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int CNT_W    = (PERIOD_W > CNT_W_TO) ? PERIOD_W : CNT_W_TO;

  localparam logic [2:0]       FILT_TOP = 3'(FILT_LEN - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W:0]   PER_MAX  = (CNT_W+1)'((64'd1 << PERIOD_W) - 64'd1);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_MOVING = 1'b1;

  // Parameter sanity: the filter counter holds at most 8 samples
  generate
    if (FILT_LEN < 1 || FILT_LEN > 8 || DIR_SETUP < 1 || TIMEOUT < 1) begin : g_bad_param
      $error("step_dir_decoder: parameter out of range");
    end
  endgenerate

  // Bit 0 = STEP, bit 1 = DIR
  logic [1:0] sync1_q;
  logic [1:0] sync2_q;
  logic [1:0] filt_q;
  logic [2:0] fcnt_q [2];
  logic       step_prev_q;

  logic [0:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                pvalid_q, pvalid_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic                svalid_q;
  logic                sdir_q;

  logic                w_accept;
  logic                w_setup_viol;
  logic [CNT_W:0]      w_cnt_plus1;
  logic [PERIOD_W-1:0] w_period_sat;

  // Two-flop synchroniser on both asynchronous lines
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
    end else begin
      sync1_q <= {bus.dir_in, bus.step_in};
      sync2_q <= sync1_q;
    end
  end

  // Filtered level follows only after FILT_LEN consecutive differing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q      <= 2'b00;
      fcnt_q[0]   <= 3'd0;
      fcnt_q[1]   <= 3'd0;
      step_prev_q <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          fcnt_q[i] <= 3'd0;
        end else if (fcnt_q[i] == FILT_TOP) begin
          filt_q[i] <= sync2_q[i];
          fcnt_q[i] <= 3'd0;
        end else begin
          fcnt_q[i] <= fcnt_q[i] + 3'd1;
        end
      end
      step_prev_q <= filt_q[0];
    end
  end

  // A filtered STEP rising edge is accepted only if enabled on that cycle
  assign w_accept = filt_q[0] & ~step_prev_q & bus.enable_in;

  assign w_cnt_plus1  = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
  assign w_period_sat = (w_cnt_plus1 > PER_MAX) ? PER_MAX[PERIOD_W-1:0]
                                                : w_cnt_plus1[PERIOD_W-1:0];

  // Next state for idle/moving tracking, interval counter and period
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    pvalid_d = 1'b0;
    if (cnt_q != {CNT_W{1'b1}}) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    if (w_accept) begin
      cnt_d   = '0;
      state_d = ST_MOVING;
      // Only a step that follows another step has an interval to report
      if (state_q == ST_MOVING) begin
        period_d = w_period_sat;
        pvalid_d = 1'b1;
      end
    end else if (state_q == ST_MOVING && cnt_q == TO_LAST) begin
      state_d = ST_IDLE;
    end
  end

  // Next position: clear overrides the step but the pulse still goes out
  always_comb begin
    pos_d = pos_q;
    if (bus.clear) begin
      pos_d = '0;
    end else if (w_accept) begin
      pos_d = filt_q[1] ? pos_q + {{(POS_W-1){1'b0}}, 1'b1}
                        : pos_q - {{(POS_W-1){1'b0}}, 1'b1};
    end
  end

  // Register state, counter, position and step outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      pvalid_q <= 1'b0;
      pos_q    <= '0;
      svalid_q <= 1'b0;
      sdir_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      pvalid_q <= pvalid_d;
      pos_q    <= pos_d;
      svalid_q <= w_accept;
      if (w_accept) begin
        sdir_q <= filt_q[1];
      end
    end
  end

`ifdef STEP_DECODER_DIR_CHECK_EN
  localparam int              SET_W   = $clog2(DIR_SETUP + 2);
  localparam logic [SET_W-1:0] SET_SAT = SET_W'(DIR_SETUP);

  logic             dir_prev_q;
  logic [SET_W-1:0] setup_q;
  logic [SET_W-1:0] w_since;
  logic             w_dir_chg;
  logic             dir_err_q;

  assign w_dir_chg = filt_q[1] ^ dir_prev_q;
  // Cycles elapsed between the filtered DIR change and this clock edge
  assign w_since   = w_dir_chg ? SET_W'(1) : setup_q + SET_W'(1);
  assign w_setup_viol = w_accept && (w_since < SET_SAT);

  // Setup counter: starts saturated so no DIR change is implied by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_prev_q <= 1'b0;
      setup_q    <= SET_SAT;
    end else begin
      dir_prev_q <= filt_q[1];
      if (w_dir_chg) begin
        setup_q <= SET_W'(1);
      end else if (setup_q != SET_SAT) begin
        setup_q <= setup_q + SET_W'(1);
      end
    end
  end

  // Sticky setup-violation flag, cleared by clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_err_q <= 1'b0;
    end else if (bus.clear) begin
      dir_err_q <= 1'b0;
    end else if (w_setup_viol) begin
      dir_err_q <= 1'b1;
    end
  end

  assign bus.dir_err = dir_err_q;
`else
  assign w_setup_viol = 1'b0;
  assign bus.dir_err  = w_setup_viol;
`endif

  assign bus.position     = pos_q;
  assign bus.step_valid   = svalid_q;
  assign bus.step_dir     = sdir_q;
  assign bus.period       = period_q;
  assign bus.period_valid = pvalid_q;
  assign bus.moving       = (state_q == ST_MOVING);

endmodule
`default_nettype wire

// File: tb/tb_step_dir_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_step_dir_decoder
//  Purpose  : Directed self-checking bench for step_dir_decoder. A second
//             instance with a 4-bit position shares the same stimulus to
//             exercise signed wrap-around cheaply.
//  Revision : 1.0  initial release
// ============================================================================
module tb_step_dir_decoder;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_chk;
  int   n_err;
  int   sv_cnt;
  int   pv_cnt;

  step_dir_decoder_if #(.POS_W(17), .PERIOD_W(20)) bus ();
  step_dir_decoder_if #(.POS_W(4),  .PERIOD_W(20)) bus2 ();

  step_dir_decoder #(
    .POS_W(17), .PERIOD_W(20), .FILT_LEN(3), .DIR_SETUP(27), .TIMEOUT(5000)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  step_dir_decoder #(
    .POS_W(4), .PERIOD_W(20), .FILT_LEN(3), .DIR_SETUP(27), .TIMEOUT(5000)
  ) u_dut_small (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2.slave)
  );

  assign bus2.step_in   = bus.step_in;
  assign bus2.dir_in    = bus.dir_in;
  assign bus2.enable_in = bus.enable_in;
  assign bus2.clear     = bus.clear;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Count output pulses, sampled away from the active edge
  always @(negedge clk) begin
    if (bus.step_valid === 1'b1)   sv_cnt <= sv_cnt + 1;
    if (bus.period_valid === 1'b1) pv_cnt <= pv_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int hi, input int lo);
    bus.step_in = 1'b1;
    tick(hi);
    bus.step_in = 1'b0;
    tick(lo);
  endtask

  int  sv0;
  int  pv0;
  logic exp_derr;

  initial begin
    cyc = 0; n_chk = 0; n_err = 0; sv_cnt = 0; pv_cnt = 0;
`ifdef STEP_DECODER_DIR_CHECK_EN
    exp_derr = 1'b1;
`else
    exp_derr = 1'b0;
`endif
    rst_n         = 1'b0;
    bus.step_in   = 1'b0;
    bus.dir_in    = 1'b1;
    bus.enable_in = 1'b1;
    bus.clear     = 1'b0;

    // ---- reset state
    tick(3);
    chk("rst_position",     32'(bus.position),     32'h0);
    chk("rst_step_valid",   32'(bus.step_valid),   32'h0);
    chk("rst_moving",       32'(bus.moving),       32'h0);
    chk("rst_period",       32'(bus.period),       32'h0);
    chk("rst_period_valid", 32'(bus.period_valid), 32'h0);
    chk("rst_dir_err",      32'(bus.dir_err),      32'h0);
    rst_n = 1'b1;
    tick(50);

    // ---- 10 clean plus steps, latency of the first one
    sv0 = sv_cnt; pv0 = pv_cnt;
    bus.step_in = 1'b1;
    tick(5);
    chk("lat_before", 32'(bus.step_valid), 32'h0);
    tick(1);
    chk("lat_at6",    32'(bus.step_valid), 32'h1);
    chk("first_pos",  32'(bus.position),   32'h1);
    chk("first_dir",  32'(bus.step_dir),   32'h1);
    chk("first_pv",   32'(bus.period_valid), 32'h0);
    tick(14);
    bus.step_in = 1'b0;
    tick(20);
    for (int i = 0; i < 9; i++) pulse(20, 20);
    tick(10);
    chk("plus10_pos",    32'(bus.position),  32'd10);
    chk("plus10_cnt",    32'(sv_cnt - sv0),  32'd10);
    chk("plus10_pvcnt",  32'(pv_cnt - pv0),  32'd9);
    chk("plus10_period", 32'(bus.period),    32'd40);
    chk("plus10_moving", 32'(bus.moving),    32'h1);
    chk("small_wrap_up", 32'(bus2.position), 32'hA);

    // ---- 15 minus steps: 10 -> -5
    bus.dir_in = 1'b0;
    tick(50);
    for (int i = 0; i < 15; i++) pulse(20, 20);
    tick(10);
    chk("minus_pos",       32'(bus.position),  32'h1FFFB);
    chk("minus_dir",       32'(bus.step_dir),  32'h0);
    chk("small_wrap_down", 32'(bus2.position), 32'hB);

    // ---- period and timeout with steps every 1000 cycles
    tick(5100);
    chk("idle_after_gap", 32'(bus.moving), 32'h0);
    for (int k = 0; k < 3; k++) begin
      bus.step_in = 1'b1;
      tick(6);
      chk("p_step_valid", 32'(bus.step_valid), 32'h1);
      if (k == 0) begin
        chk("p_first_pv",     32'(bus.period_valid), 32'h0);
        chk("p_first_period", 32'(bus.period),       32'd40);
        chk("p_first_moving", 32'(bus.moving),       32'h1);
      end else begin
        chk("p_pv",     32'(bus.period_valid), 32'h1);
        chk("p_period", 32'(bus.period),       32'd1000);
      end
      if (k < 2) begin
        tick(14);
        bus.step_in = 1'b0;
        tick(980);
      end else begin
        bus.step_in = 1'b0;
        tick(4999);
        chk("to_still_moving", 32'(bus.moving), 32'h1);
        tick(1);
        chk("to_idle",         32'(bus.moving), 32'h0);
      end
    end
    chk("p_pos", 32'(bus.position), 32'h1FFF8);

    // ---- glitch rejection, then a minimum-width pulse
    tick(100);
    sv0 = sv_cnt;
    for (int i = 0; i < 3; i++) pulse(2, 10);
    chk("glitch_cnt", 32'(sv_cnt - sv0), 32'd0);
    chk("glitch_pos", 32'(bus.position), 32'h1FFF8);
    pulse(3, 10);
    chk("min_pulse_cnt", 32'(sv_cnt - sv0), 32'd1);
    chk("min_pulse_pos", 32'(bus.position), 32'h1FFF7);

    // ---- clear on the same cycle as an accepted step
    bus.step_in = 1'b1;
    tick(5);
    bus.clear = 1'b1;
    tick(1);
    chk("clr_step_valid", 32'(bus.step_valid), 32'h1);
    chk("clr_pos",        32'(bus.position),   32'h0);
    bus.clear = 1'b0;
    tick(14);
    bus.step_in = 1'b0;
    tick(20);
    chk("clr_pos_hold", 32'(bus.position), 32'h0);

    // ---- steps while disabled are lost
    bus.enable_in = 1'b0;
    sv0 = sv_cnt;
    for (int i = 0; i < 5; i++) pulse(20, 20);
    chk("dis_cnt", 32'(sv_cnt - sv0), 32'd0);
    chk("dis_pos", 32'(bus.position), 32'h0);
    bus.enable_in = 1'b1;
    pulse(20, 20);
    chk("reen_pos", 32'(bus.position), 32'h1FFFF);

    // ---- DIR setup check: short setup, then long setup
    bus.clear = 1'b1;
    tick(1);
    bus.clear = 1'b0;
    bus.dir_in = 1'b1;
    tick(10);
    pulse(20, 20);
    chk("setup_short_err", 32'(bus.dir_err),  32'(exp_derr));
    chk("setup_short_pos", 32'(bus.position), 32'h1);
    bus.clear = 1'b1;
    tick(1);
    bus.clear = 1'b0;
    tick(1);
    chk("setup_cleared", 32'(bus.dir_err), 32'h0);
    bus.dir_in = 1'b0;
    tick(40);
    pulse(20, 20);
    chk("setup_long_err", 32'(bus.dir_err),  32'h0);
    chk("setup_long_pos", 32'(bus.position), 32'h1FFFF);

    // ---- asynchronous reset mid-operation
    rst_n = 1'b0;
    #1;
    chk("arst_pos",    32'(bus.position), 32'h0);
    chk("arst_moving", 32'(bus.moving),   32'h0);
    tick(2);
    rst_n = 1'b1;
    tick(10);
    pulse(20, 20);
    chk("post_rst_pos", 32'(bus.position),     32'h1FFFF);
    chk("post_rst_pv",  32'(bus.period_valid), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
